// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling and one-cycle DV / framing-error strobes.
// Define UART_RX_PARITY_EN to expect an even-parity bit and add o_Rx_Parity_Err.
module uart_rx #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       i_Clock,
    input  logic       i_Rst_L,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Active,
`ifdef UART_RX_PARITY_EN
    output logic       o_Rx_Parity_Err,
`endif
    output logic       o_Rx_Frame_Err
);

    localparam logic [7:0] BIT_LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [7:0] HALF_BIT = 8'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP    = 3'd4,
        CLEANUP = 3'd5,
        BREAK   = 3'd6
    } state_t;

    state_t     state_q, state_d;
    logic       rx_meta, rx_s;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] data_q, data_d;
    logic [7:0] byte_d;
    logic       dv_d, ferr_d, active_d;
    logic       par_ok;
`ifdef UART_RX_PARITY_EN
    logic       par_q, par_d, perr_d;
    assign par_ok = ~(^{data_q, par_q});
`else
    assign par_ok = 1'b1;
`endif

    // Two-flop synchroniser; both stages reset to the idle (high) line level.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_Rx_Serial;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            idx_q          <= '0;
            data_q         <= '0;
            o_Rx_Byte      <= '0;
            o_Rx_DV        <= 1'b0;
            o_Rx_Frame_Err <= 1'b0;
            o_Rx_Active    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q           <= 1'b0;
            o_Rx_Parity_Err <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            data_q         <= data_d;
            o_Rx_Byte      <= byte_d;
            o_Rx_DV        <= dv_d;
            o_Rx_Frame_Err <= ferr_d;
            o_Rx_Active    <= active_d;
`ifdef UART_RX_PARITY_EN
            par_q           <= par_d;
            o_Rx_Parity_Err <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        data_d   = data_q;
        byte_d   = o_Rx_Byte;
        dv_d     = 1'b0;
        ferr_d   = 1'b0;
        active_d = o_Rx_Active;
`ifdef UART_RX_PARITY_EN
        par_d    = par_q;
        perr_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cnt_d    = '0;
                idx_d    = '0;
                active_d = 1'b0;
                if (!rx_s) begin
                    state_d  = START;
                    active_d = 1'b1;
                end
            end
            // A start bit that is high again at mid-bit was only a glitch.
            START: begin
                if (cnt_q == HALF_BIT) begin
                    if (!rx_s) begin
                        cnt_d   = '0;
                        state_d = DATA;
                    end else begin
                        state_d  = IDLE;
                        active_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d         = '0;
                    data_d[idx_q] = rx_s;
                    if (idx_q == 3'd7) begin
                        idx_d   = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    par_d   = rx_s;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
`endif
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                    perr_d = ~par_ok;
`endif
                    if (rx_s) begin
                        state_d = CLEANUP;
                        if (par_ok) begin
                            byte_d = data_q;
                            dv_d   = 1'b1;
                        end
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            CLEANUP: begin
                active_d = 1'b0;
                state_d  = IDLE;
            end
            // Hold off until the line returns high so a stuck-low line is not decoded as 0x00 frames.
            BREAK: begin
                if (rx_s) begin
                    active_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                cnt_d    = '0;
                idx_d    = '0;
                active_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven frames plus hand sequences for glitch, break and reset abort.
// Received strobes are matched against a queue of expected events.
module tb_uart_rx;

    localparam int CPB = 10;

    typedef enum int {EV_DV, EV_FERR, EV_PERR} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [7:0] data;
    } ev_t;
    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        int         hold_low;
        int         gap;
        ev_kind_t   exp_kind;
        logic [7:0] exp_byte;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       dv, active, ferr, perr;
    logic [7:0] rx_byte;

    ev_t      exp_q[$];
    ev_t      exp_ev;
    ev_kind_t got_kind;
    int       tests = 0;
    int       fails = 0;
    int       strobes = 0;
    int       strobes_before;
    vec_t     vecs[6];
    vec_t     v_3c, v_c3;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock        (clk),
        .i_Rst_L        (rst_n),
        .i_Rx_Serial    (rx),
        .o_Rx_DV        (dv),
        .o_Rx_Byte      (rx_byte),
        .o_Rx_Active    (active),
`ifdef UART_RX_PARITY_EN
        .o_Rx_Parity_Err(perr),
`endif
        .o_Rx_Frame_Err (ferr)
    );
`ifndef UART_RX_PARITY_EN
    assign perr = 1'b0;
`endif

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && (dv || ferr || perr)) begin
            strobes++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("[TB] FAIL unexpected_strobe got dv=%0b ferr=%0b perr=%0b byte=%02h, expected none",
                         dv, ferr, perr, rx_byte);
            end else begin
                exp_ev   = exp_q.pop_front();
                got_kind = dv ? EV_DV : (ferr ? EV_FERR : EV_PERR);
                if ((dv && (ferr || perr)) || got_kind != exp_ev.kind ||
                    (dv && rx_byte != exp_ev.data)) begin
                    fails++;
                    $display("[TB] FAIL strobe got kind=%0d dv=%0b ferr=%0b perr=%0b byte=%02h, expected kind=%0d byte=%02h",
                             got_kind, dv, ferr, perr, rx_byte, exp_ev.kind, exp_ev.data);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s got %02h expected %02h", name, got, exp);
        end
    endtask

    task automatic sendBit(input logic b);
        @(negedge clk) rx = b;
        repeat (CPB - 1) @(negedge clk);
    endtask

    task automatic sendFrame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                @(negedge clk) rx = d[i];
                repeat (4) @(negedge clk);
                checkOutput("active_mid_frame", {7'd0, active}, 8'h01);
                repeat (CPB - 5) @(negedge clk);
            end else begin
                sendBit(d[i]);
            end
        end
`ifdef UART_RX_PARITY_EN
        sendBit((^d) ^ par_flip);
`else
        if (par_flip) $display("[TB] parity flip ignored without parity build");
`endif
        sendBit(stop_bit);
    endtask

    task automatic waitDrain(input string name);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL %s_timeout got %0d pending expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_q.push_back('{kind: v.exp_kind, data: v.exp_byte});
        sendFrame(v.data, v.stop_bit, 1'b0);
        if (v.hold_low > 0) begin
            repeat (v.hold_low) @(negedge clk);
            checkOutput("break_active", {7'd0, active}, 8'h01);
            checkOutput("byte_held", rx_byte, v.exp_byte);
            rx = 1'b1;
        end
        repeat (v.gap) @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 0,  20, EV_DV,   8'hA5};
        vecs[1] = '{8'h5A, 1'b0, 40, 20, EV_FERR, 8'hA5};
        vecs[2] = '{8'h81, 1'b1, 0,  20, EV_DV,   8'h81};
        vecs[3] = '{8'h00, 1'b1, 0,  0,  EV_DV,   8'h00};
        vecs[4] = '{8'hFF, 1'b1, 0,  0,  EV_DV,   8'hFF};
        vecs[5] = '{8'h55, 1'b1, 0,  20, EV_DV,   8'h55};
        v_3c    = '{8'h3C, 1'b1, 0,  20, EV_DV,   8'h3C};
        v_c3    = '{8'hC3, 1'b1, 0,  20, EV_DV,   8'hC3};

        repeat (3) @(negedge clk);
        checkOutput("reset_dv", {7'd0, dv}, 8'h00);
        checkOutput("reset_byte", rx_byte, 8'h00);
        checkOutput("reset_active", {7'd0, active}, 8'h00);
        checkOutput("reset_ferr", {7'd0, ferr}, 8'h00);
        rst_n = 1'b1;
        repeat (500) @(negedge clk);
        checkOutput("idle_strobes", 8'(strobes), 8'h00);
        checkOutput("idle_active", {7'd0, active}, 8'h00);
        checkOutput("idle_byte", rx_byte, 8'h00);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i]);
            if (vecs[i].gap > 0) waitDrain("table");
        end
        checkOutput("last_byte", rx_byte, 8'h55);

        strobes_before = strobes;
        @(negedge clk) rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("glitch_active", {7'd0, active}, 8'h00);
        checkOutput("glitch_strobes", 8'(strobes - strobes_before), 8'h00);
        applyStimulus(v_3c);
        waitDrain("after_glitch");

        sendBit(1'b0);
        for (int i = 0; i < 4; i++) sendBit(i[0]);
        @(negedge clk) rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_active", {7'd0, active}, 8'h00);
        checkOutput("abort_byte", rx_byte, 8'h00);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("post_reset_active", {7'd0, active}, 8'h00);
        applyStimulus(v_c3);
        waitDrain("after_reset");

`ifdef UART_RX_PARITY_EN
        exp_q.push_back('{kind: EV_PERR, data: 8'hC3});
        sendFrame(8'hC3, 1'b1, 1'b1);
        repeat (20) @(negedge clk);
        waitDrain("parity");
        checkOutput("parity_byte_held", rx_byte, 8'hC3);
`endif

        repeat (20) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver that pairs with the team's existing UART transmitter.
- Frame format: 8 data bits, 1 start bit, 1 stop bit, no parity by default.
- Samples the asynchronous serial line at mid-bit and delivers each received byte with a single-cycle valid strobe.
- Reports framing errors.
- Sits between the device RX pad and the command/loopback logic.

Parameters:
- CLKS_PER_BIT, 10: i_Clock cycles per UART bit (Frequency of i_Clock / baud). Legal range 4..255. Must match the transmitter for loopback.

Ports:
- i_Clock  input  1  system clock; all logic on the rising edge.
- i_Rst_L  input  1  asynchronous active-low reset.
- i_Rx_Serial  input  1  asynchronous serial line; idle high.
- o_Rx_DV  output  1  one-cycle strobe: o_Rx_Byte holds a newly received byte.
- o_Rx_Byte  output  8  last good byte, LSB received first.
- o_Rx_Active  output  1  high while a frame is being received.
- o_Rx_Frame_Err  output  1  one-cycle strobe: stop bit sampled low.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (i_Rst_L), and is fixed that way. While i_Rst_L is low, every register clears asynchronously:
  - outputs: o_Rx_DV=0, o_Rx_Byte=0x00, o_Rx_Active=0, o_Rx_Frame_Err=0;
  - state=IDLE, counters=0;
  - both synchroniser flops=1 (line idle).
- Reset mid-frame aborts the frame with no strobe. After release the block hunts for a new start edge.
- Input sync: 2-flop synchroniser on i_Rx_Serial. All decisions use the second flop (rx_s). This adds 2 cycles of fixed latency.
- Counters: 8-bit clock counter, 3-bit bit index, 8-bit shift/hold register.
- IDLE:
  - Clock counter and bit index held at 0; o_Rx_Active=0.
  - rx_s==0 -> START; o_Rx_Active<=1.
- START:
  - Counter counts up to (CLKS_PER_BIT-1)/2 (integer divide). At that count, rx_s is sampled.
  - rx_s==0 -> counter<=0, go to DATA.
  - rx_s==1 -> glitch: go to IDLE, o_Rx_Active<=0, no strobe.
- DATA:
  - Counter counts 0..CLKS_PER_BIT-1. At CLKS_PER_BIT-1, rx_s is written to data[bit_index] and the counter clears.
  - bit_index<7 -> increment bit_index.
  - bit_index==7 -> bit_index<=0, go to STOP.
- STOP:
  - After CLKS_PER_BIT-1 counts, rx_s is sampled.
  - Sample 1 -> o_Rx_Byte<=data, o_Rx_DV<=1, go to CLEANUP.
  - Sample 0 -> o_Rx_Frame_Err<=1, o_Rx_Byte unchanged, go to BREAK.
- CLEANUP (one cycle): o_Rx_DV<=0, o_Rx_Active<=0, go to IDLE.
- BREAK:
  - o_Rx_Frame_Err<=0; o_Rx_Active stays 1.
  - Stays in BREAK until rx_s==1, then o_Rx_Active<=0 and go to IDLE.
  - This prevents a held-low line from being decoded as repeated 0x00 frames.
- Strobes:
  - o_Rx_DV and o_Rx_Frame_Err are registered, exactly one cycle wide, and never high together.
  - o_Rx_Byte is stable from the DV cycle until the next DV.
- Back-to-back frames: a start edge arriving during CLEANUP is caught in IDLE on the next cycle, because the stop sample is taken at mid-bit, leaving about half a bit of margin. No bytes are lost at full line rate.
- Undefined state encodings -> IDLE.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP. The parity bit is sampled after CLKS_PER_BIT-1 counts.
  - Even parity is checked: XOR of the 8 data bits and the parity bit must be 0.
  - A port o_Rx_Parity_Err (output, 1) is added. On mismatch it pulses for one cycle, coincident with the STOP-state decision.
  - On mismatch o_Rx_DV is suppressed and o_Rx_Byte is unchanged.
  - If the stop bit is also 0, both o_Rx_Frame_Err and o_Rx_Parity_Err pulse in that cycle.
- When undefined: no PARITY state, no port, 10-bit frame exactly as above.

Test Plan:
- Reset release, line idle: all outputs 0, o_Rx_Byte=0x00, no strobes for 500 cycles.
- CLKS_PER_BIT=10, serialise 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1): exactly one o_Rx_DV pulse, o_Rx_Byte=0xA5, o_Rx_Frame_Err never high, o_Rx_Active high across the frame.
- 3-cycle low glitch on an idle line: no DV, no Frame_Err; o_Rx_Active returns to 0 by about cycle 8; a following 0x3C frame is still received correctly.
- 0x5A frame with stop bit 0, line then held low 40 cycles: one Frame_Err pulse, no DV, o_Rx_Byte keeps the previous 0xA5, no further strobes until the line goes high, then 0x81 received correctly.
- Back-to-back 0x00, 0xFF, 0x55 with no idle gap: three DV pulses in order with matching bytes.
- Assert i_Rst_L low at data bit 4 of a frame, release, send 0xC3: no strobe for the aborted frame, 0xC3 received. With UART_RX_PARITY_EN, 0xC3 with bad parity bit 1: o_Rx_Parity_Err pulses, no DV.
